ex_stage: RTL and testbench

Execute stage of the rv32i five-stage pipeline: consumes the ID/EX bundle produced by the decode stage and drives the EX/MEM pipeline register. It selects forwarded operands, performs ALU operations, resolves branches and jumps, and issues a registered redirect (target PC plus flush request) when the fetch-stage direction prediction was wrong. On redirect it also squashes the one wrong-path instruction already latched in ID/EX.

---
 rtl/rv32i_pkg.sv | 70 +++++++
 rtl/ex_stage_alu.sv | 57 +++++
 rtl/ex_stage.sv | 153 +++++++++++++++
 tb/tb_ex_stage.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared rv32i definitions: ALUOp codes, funct3 encodings, execute-stage FSM
// states, the EX/MEM payload and the operand forwarding helper.
package rv32i_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef enum logic [1:0] {
    ALUOP_ADD    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_ITYPE  = 2'b11
  } alu_op_e;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } ex_state_e;

  typedef struct packed {
    logic              enable;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   store_data;
    logic [REG_AW-1:0] rd;
    logic [2:0]        funct3;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              reg_write;
    logic              redirect;
    logic [XLEN-1:0]   redirect_pc;
  } ex_mem_t;

  // EX/MEM beats MEM/WB; x0 always reads the register file.
  function automatic logic [XLEN-1:0] fwd_operand(
    input logic [REG_AW-1:0] idx,
    input logic [XLEN-1:0]   rf_val,
    input logic              exm_wr,
    input logic [REG_AW-1:0] exm_rd,
    input logic [XLEN-1:0]   exm_val,
    input logic              wb_wr,
    input logic [REG_AW-1:0] wb_rd,
    input logic [XLEN-1:0]   wb_val
  );
    logic [XLEN-1:0] val;
    val = rf_val;
    if (idx != '0) begin
      if (exm_wr && (exm_rd == idx))     val = exm_val;
      else if (wb_wr && (wb_rd == idx))  val = wb_val;
    end
    return val;
  endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational rv32i ALU plus branch condition evaluation.
module alu
  import rv32i_pkg::*;
(
  input  alu_op_e         alu_op,
  input  logic [2:0]      funct3,
  input  logic            funct7_b5,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result_c,
  output logic            br_cond_c
);

  logic [4:0] shamt;
  logic       lt_s;
  logic       lt_u;

  assign shamt = b[4:0];
  assign lt_s  = $signed(a) < $signed(b);
  assign lt_u  = a < b;

  // SUB only exists for R-type; SRA/SRAI both key off funct7[5].
  always_comb begin
    result_c = a + b;
    case (alu_op)
      ALUOP_ADD:    result_c = a + b;
      ALUOP_BRANCH: result_c = a - b;
      default: begin
        case (funct3)
          F3_ADD:  result_c = ((alu_op == ALUOP_RTYPE) && funct7_b5) ? (a - b) : (a + b);
          F3_SLL:  result_c = a << shamt;
          F3_SLT:  result_c = {{(XLEN-1){1'b0}}, lt_s};
          F3_SLTU: result_c = {{(XLEN-1){1'b0}}, lt_u};
          F3_XOR:  result_c = a ^ b;
          F3_SRL:  result_c = funct7_b5 ? XLEN'($signed(a) >>> shamt) : (a >> shamt);
          F3_OR:   result_c = a | b;
          F3_AND:  result_c = a & b;
          default: result_c = a + b;
        endcase
      end
    endcase
  end

  always_comb begin
    br_cond_c = 1'b0;
    case (funct3)
      F3_BEQ:  br_cond_c = (a == b);
      F3_BNE:  br_cond_c = (a != b);
      F3_BLT:  br_cond_c = lt_s;
      F3_BGE:  br_cond_c = !lt_s;
      F3_BLTU: br_cond_c = lt_u;
      F3_BGEU: br_cond_c = !lt_u;
      default: br_cond_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// rv32i execute stage: forwarding, ALU, branch/jump resolution, registered
// redirect and single-slot squash of the wrong-path instruction.
module ex_stage
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_stall,
  input  logic              ID_EX_enable_out,
  input  logic [XLEN-1:0]   ID_EX_PC,
  input  logic [XLEN-1:0]   ID_EX_Immediate,
  input  logic [REG_AW-1:0] ID_EX_Rs1,
  input  logic [REG_AW-1:0] ID_EX_Rs2,
  input  logic [REG_AW-1:0] ID_EX_Rd,
  input  logic [6:0]        ID_EX_Funct7,
  input  logic [2:0]        ID_EX_Funct3,
  input  logic              ID_EX_ALUSrc,
  input  logic              ID_EX_Branch,
  input  logic              ID_EX_Jump,
  input  logic              ID_EX_MemRead,
  input  logic              ID_EX_MemWrite,
  input  logic              ID_EX_MemToReg,
  input  logic              ID_EX_RegWrite,
  input  logic [1:0]        ID_EX_ALUOp,
  input  logic              ID_EX_jump_branch_taken,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic              MEM_WB_RegWrite,
  input  logic [REG_AW-1:0] MEM_WB_Rd,
  input  logic [XLEN-1:0]   MEM_WB_WriteData,
  output logic              EX_MEM_enable_out,
  output logic [XLEN-1:0]   EX_MEM_ALUResult,
  output logic [XLEN-1:0]   EX_MEM_StoreData,
  output logic [REG_AW-1:0] EX_MEM_Rd,
  output logic [2:0]        EX_MEM_Funct3,
  output logic              EX_MEM_MemRead,
  output logic              EX_MEM_MemWrite,
  output logic              EX_MEM_MemToReg,
  output logic              EX_MEM_RegWrite,
  output logic              EX_MEM_redirect,
  output logic [XLEN-1:0]   EX_MEM_redirect_pc
);

  ex_state_e       state_q, state_d;
  ex_mem_t         ex_mem_q, ex_mem_d;

  logic            slot_valid_c;
  logic            redirect_c;
  logic            taken_c;
  logic            br_cond_c;
  logic [XLEN-1:0] fwd_rs1_c;
  logic [XLEN-1:0] fwd_rs2_c;
  logic [XLEN-1:0] alu_b_c;
  logic [XLEN-1:0] alu_res_c;
  logic [XLEN-1:0] pc_plus4_c;
  logic [XLEN-1:0] jalr_sum_c;
  logic [XLEN-1:0] target_c;
  logic            unused_funct7;

  assign unused_funct7 = ^{ID_EX_Funct7[6], ID_EX_Funct7[4:0]};

  always_comb begin
    fwd_rs1_c = fwd_operand(ID_EX_Rs1, rs1_data,
                            ex_mem_q.enable & ex_mem_q.reg_write, ex_mem_q.rd, ex_mem_q.alu_result,
                            MEM_WB_RegWrite, MEM_WB_Rd, MEM_WB_WriteData);
    fwd_rs2_c = fwd_operand(ID_EX_Rs2, rs2_data,
                            ex_mem_q.enable & ex_mem_q.reg_write, ex_mem_q.rd, ex_mem_q.alu_result,
                            MEM_WB_RegWrite, MEM_WB_Rd, MEM_WB_WriteData);
    alu_b_c   = ID_EX_ALUSrc ? ID_EX_Immediate : fwd_rs2_c;
  end

  alu u_alu (
    .alu_op    (alu_op_e'(ID_EX_ALUOp)),
    .funct3    (ID_EX_Funct3),
    .funct7_b5 (ID_EX_Funct7[5]),
    .a         (fwd_rs1_c),
    .b         (alu_b_c),
    .result_c  (alu_res_c),
    .br_cond_c (br_cond_c)
  );

  // JALR is the only jump that uses the immediate as operand B.
  always_comb begin
    pc_plus4_c = ID_EX_PC + XLEN'(4);
    jalr_sum_c = fwd_rs1_c + ID_EX_Immediate;
    target_c   = (ID_EX_Jump && ID_EX_ALUSrc) ? {jalr_sum_c[XLEN-1:1], 1'b0}
                                               : (ID_EX_PC + ID_EX_Immediate);
    taken_c    = ID_EX_Jump | (ID_EX_Branch & br_cond_c);
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!mem_stall) begin
      case (state_q)
        ST_RUN:    if (redirect_c) state_d = ST_SQUASH;
        ST_SQUASH: state_d = ST_RUN;
        default:   state_d = ST_RUN;
      endcase
    end
  end

  // The slot after a redirect is wrong-path and is dropped.
  always_comb begin
    slot_valid_c = ID_EX_enable_out && (state_q == ST_RUN);
    redirect_c   = slot_valid_c && (taken_c != ID_EX_jump_branch_taken);
  end

  always_comb begin
    ex_mem_d = ex_mem_q;
    if (!mem_stall) begin
      ex_mem_d.enable     = slot_valid_c;
      ex_mem_d.alu_result = ID_EX_Jump ? pc_plus4_c : alu_res_c;
      ex_mem_d.store_data = fwd_rs2_c;
      ex_mem_d.rd         = ID_EX_Rd;
      ex_mem_d.funct3     = ID_EX_Funct3;
      ex_mem_d.mem_read   = slot_valid_c & ID_EX_MemRead;
      ex_mem_d.mem_write  = slot_valid_c & ID_EX_MemWrite;
      ex_mem_d.mem_to_reg = slot_valid_c & ID_EX_MemToReg;
      ex_mem_d.reg_write  = slot_valid_c & ID_EX_RegWrite;
      ex_mem_d.redirect   = redirect_c;
      if (redirect_c) ex_mem_d.redirect_pc = taken_c ? target_c : pc_plus4_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_mem_q             <= '0;
      ex_mem_q.redirect_pc <= RESET_PC;
    end else begin
      ex_mem_q <= ex_mem_d;
    end
  end

  assign EX_MEM_enable_out  = ex_mem_q.enable;
  assign EX_MEM_ALUResult   = ex_mem_q.alu_result;
  assign EX_MEM_StoreData   = ex_mem_q.store_data;
  assign EX_MEM_Rd          = ex_mem_q.rd;
  assign EX_MEM_Funct3      = ex_mem_q.funct3;
  assign EX_MEM_MemRead     = ex_mem_q.mem_read;
  assign EX_MEM_MemWrite    = ex_mem_q.mem_write;
  assign EX_MEM_MemToReg    = ex_mem_q.mem_to_reg;
  assign EX_MEM_RegWrite    = ex_mem_q.reg_write;
  assign EX_MEM_redirect    = ex_mem_q.redirect;
  assign EX_MEM_redirect_pc = ex_mem_q.redirect_pc;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: instruction-level reference model feeds an
// expectation queue that a free-running monitor drains after each clock edge.
`timescale 1ns/1ps
module tb_ex_stage;

  localparam logic [31:0] RST_PC = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_stall = 1'b0;
  logic        ID_EX_enable_out = 1'b0;
  logic [31:0] ID_EX_PC = '0, ID_EX_Immediate = '0;
  logic [4:0]  ID_EX_Rs1 = '0, ID_EX_Rs2 = '0, ID_EX_Rd = '0;
  logic [6:0]  ID_EX_Funct7 = '0;
  logic [2:0]  ID_EX_Funct3 = '0;
  logic        ID_EX_ALUSrc = 1'b0, ID_EX_Branch = 1'b0, ID_EX_Jump = 1'b0;
  logic        ID_EX_MemRead = 1'b0, ID_EX_MemWrite = 1'b0, ID_EX_MemToReg = 1'b0, ID_EX_RegWrite = 1'b0;
  logic [1:0]  ID_EX_ALUOp = '0;
  logic        ID_EX_jump_branch_taken = 1'b0;
  logic [31:0] rs1_data = '0, rs2_data = '0;
  logic        MEM_WB_RegWrite = 1'b0;
  logic [4:0]  MEM_WB_Rd = '0;
  logic [31:0] MEM_WB_WriteData = '0;

  logic        EX_MEM_enable_out;
  logic [31:0] EX_MEM_ALUResult, EX_MEM_StoreData, EX_MEM_redirect_pc;
  logic [4:0]  EX_MEM_Rd;
  logic [2:0]  EX_MEM_Funct3;
  logic        EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_MemToReg, EX_MEM_RegWrite, EX_MEM_redirect;

  always #5 clk = ~clk;

  ex_stage #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .mem_stall(mem_stall),
    .ID_EX_enable_out(ID_EX_enable_out), .ID_EX_PC(ID_EX_PC), .ID_EX_Immediate(ID_EX_Immediate),
    .ID_EX_Rs1(ID_EX_Rs1), .ID_EX_Rs2(ID_EX_Rs2), .ID_EX_Rd(ID_EX_Rd),
    .ID_EX_Funct7(ID_EX_Funct7), .ID_EX_Funct3(ID_EX_Funct3),
    .ID_EX_ALUSrc(ID_EX_ALUSrc), .ID_EX_Branch(ID_EX_Branch), .ID_EX_Jump(ID_EX_Jump),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_MemWrite(ID_EX_MemWrite),
    .ID_EX_MemToReg(ID_EX_MemToReg), .ID_EX_RegWrite(ID_EX_RegWrite),
    .ID_EX_ALUOp(ID_EX_ALUOp), .ID_EX_jump_branch_taken(ID_EX_jump_branch_taken),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .MEM_WB_RegWrite(MEM_WB_RegWrite), .MEM_WB_Rd(MEM_WB_Rd), .MEM_WB_WriteData(MEM_WB_WriteData),
    .EX_MEM_enable_out(EX_MEM_enable_out), .EX_MEM_ALUResult(EX_MEM_ALUResult),
    .EX_MEM_StoreData(EX_MEM_StoreData), .EX_MEM_Rd(EX_MEM_Rd), .EX_MEM_Funct3(EX_MEM_Funct3),
    .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_MemWrite(EX_MEM_MemWrite),
    .EX_MEM_MemToReg(EX_MEM_MemToReg), .EX_MEM_RegWrite(EX_MEM_RegWrite),
    .EX_MEM_redirect(EX_MEM_redirect), .EX_MEM_redirect_pc(EX_MEM_redirect_pc)
  );

  typedef enum int {
    K_ADD, K_SUB, K_SLL, K_SLT, K_SLTU, K_XOR, K_SRL, K_SRA, K_OR, K_AND,
    K_ADDI, K_SLTI, K_SLTIU, K_XORI, K_ORI, K_ANDI, K_SLLI, K_SRLI, K_SRAI,
    K_LW, K_SW, K_BEQ, K_BNE, K_BLT, K_BGE, K_BLTU, K_BGEU, K_BNONE, K_JAL, K_JALR
  } kind_e;
  localparam int NKIND = 30;

  typedef struct {
    kind_e       kind;
    bit          valid;
    bit          pred;
    logic [31:0] pc, imm, rs1_data, rs2_data, wb_data;
    logic [4:0]  rs1, rs2, rd, wb_rd;
    bit          wb_we;
    logic [2:0]  f3;
  } instr_t;

  typedef struct {
    bit          valid, chk_res, mr, mw, m2r, rw, redir;
    logic [31:0] res, sdata, rpc;
    logic [4:0]  rd;
    logic [2:0]  f3;
  } exp_t;

  exp_t exp_q[$];
  exp_t m_prev;
  exp_t m_last;
  bit   m_squash;
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic bit is_r(kind_e k);  return k <= K_AND; endfunction
  function automatic bit is_i(kind_e k);  return k >= K_ADDI && k <= K_SRAI; endfunction
  function automatic bit is_br(kind_e k); return k >= K_BEQ && k <= K_BNONE; endfunction
  function automatic bit writes(kind_e k);
    return is_r(k) || is_i(k) || k == K_LW || k == K_JAL || k == K_JALR;
  endfunction

  function automatic logic [2:0] k_f3(instr_t in);
    case (in.kind)
      K_ADD, K_SUB, K_ADDI, K_BEQ, K_JALR:           return 3'b000;
      K_SLL, K_SLLI, K_BNE:                          return 3'b001;
      K_SLT, K_SLTI, K_LW, K_SW:                     return 3'b010;
      K_SLTU, K_SLTIU, K_BNONE:                      return 3'b011;
      K_XOR, K_XORI, K_BLT:                          return 3'b100;
      K_SRL, K_SRA, K_SRLI, K_SRAI, K_BGE:           return 3'b101;
      K_OR, K_ORI, K_BLTU:                           return 3'b110;
      K_AND, K_ANDI, K_BGEU:                         return 3'b111;
      default:                                       return in.f3;
    endcase
  endfunction

  task automatic drive(input instr_t in);
    ID_EX_enable_out = in.valid;
    ID_EX_PC = in.pc; ID_EX_Immediate = in.imm;
    ID_EX_Rs1 = in.rs1; ID_EX_Rs2 = in.rs2; ID_EX_Rd = in.rd;
    ID_EX_Funct3 = k_f3(in);
    if (is_r(in.kind)) ID_EX_Funct7 = (in.kind == K_SUB || in.kind == K_SRA) ? 7'h20 : 7'h00;
    else               ID_EX_Funct7 = in.imm[11:5];
    ID_EX_ALUSrc   = !(is_r(in.kind) || is_br(in.kind) || in.kind == K_JAL);
    ID_EX_Branch   = is_br(in.kind);
    ID_EX_Jump     = (in.kind == K_JAL) || (in.kind == K_JALR);
    ID_EX_MemRead  = (in.kind == K_LW);
    ID_EX_MemWrite = (in.kind == K_SW);
    ID_EX_MemToReg = (in.kind == K_LW);
    ID_EX_RegWrite = writes(in.kind);
    ID_EX_ALUOp    = is_r(in.kind) ? 2'b10 : is_i(in.kind) ? 2'b11 : is_br(in.kind) ? 2'b01 : 2'b00;
    ID_EX_jump_branch_taken = in.pred;
    rs1_data = in.rs1_data; rs2_data = in.rs2_data;
    MEM_WB_RegWrite = in.wb_we; MEM_WB_Rd = in.wb_rd; MEM_WB_WriteData = in.wb_data;
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] rf, input instr_t in);
    if (idx != 5'd0 && m_prev.valid && m_prev.rw && m_prev.rd == idx) return m_prev.res;
    if (idx != 5'd0 && in.wb_we && in.wb_rd == idx) return in.wb_data;
    return rf;
  endfunction

  // Instruction-level semantics of one execute step.
  function automatic exp_t model(input instr_t in);
    exp_t e;
    logic [31:0] a, b, rs2v, tgt;
    logic [4:0]  sh;
    bit taken;
    e = '{default: 0};
    if (!in.valid || m_squash) return e;
    a    = fwd(in.rs1, in.rs1_data, in);
    rs2v = fwd(in.rs2, in.rs2_data, in);
    b    = (is_i(in.kind) || in.kind == K_LW || in.kind == K_SW || in.kind == K_JALR) ? in.imm : rs2v;
    sh   = b[4:0];
    tgt  = in.pc + in.imm;
    taken = 0;
    e.valid = 1; e.chk_res = 1; e.rd = in.rd; e.f3 = k_f3(in); e.sdata = rs2v;
    case (in.kind)
      K_ADD, K_ADDI, K_LW, K_SW: e.res = a + b;
      K_SUB:            e.res = a - b;
      K_SLL, K_SLLI:    e.res = a << sh;
      K_SLT, K_SLTI:    e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      K_SLTU, K_SLTIU:  e.res = (a < b) ? 32'd1 : 32'd0;
      K_XOR, K_XORI:    e.res = a ^ b;
      K_SRL, K_SRLI:    e.res = a >> sh;
      K_SRA, K_SRAI:    e.res = 32'($signed(a) >>> sh);
      K_OR, K_ORI:      e.res = a | b;
      K_AND, K_ANDI:    e.res = a & b;
      K_BEQ:  begin e.chk_res = 0; taken = (a == b); end
      K_BNE:  begin e.chk_res = 0; taken = (a != b); end
      K_BLT:  begin e.chk_res = 0; taken = ($signed(a) < $signed(b)); end
      K_BGE:  begin e.chk_res = 0; taken = ($signed(a) >= $signed(b)); end
      K_BLTU: begin e.chk_res = 0; taken = (a < b); end
      K_BGEU: begin e.chk_res = 0; taken = (a >= b); end
      K_BNONE: e.chk_res = 0;
      K_JAL:  begin e.res = in.pc + 32'd4; taken = 1; end
      K_JALR: begin e.res = in.pc + 32'd4; taken = 1; tgt = (a + in.imm) & 32'hFFFF_FFFE; end
      default: e.chk_res = 0;
    endcase
    e.mr = (in.kind == K_LW); e.mw = (in.kind == K_SW); e.m2r = (in.kind == K_LW);
    e.rw = writes(in.kind);
    e.redir = (taken != in.pred);
    e.rpc = taken ? tgt : in.pc + 32'd4;
    return e;
  endfunction

  function automatic instr_t mk(kind_e k, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                                logic [31:0] d1, logic [31:0] d2, logic [31:0] imm);
    instr_t in;
    in.kind = k; in.valid = 1; in.pred = 0; in.pc = 32'h40; in.imm = imm;
    in.rs1 = rs1; in.rs2 = rs2; in.rd = rd; in.rs1_data = d1; in.rs2_data = d2;
    in.wb_we = 0; in.wb_rd = 5'd0; in.wb_data = 32'd0; in.f3 = 3'd0;
    return in;
  endfunction

  function automatic instr_t rand_instr();
    instr_t in;
    logic [11:0] i12;
    in.kind  = kind_e'($urandom_range(0, NKIND - 1));
    in.valid = ($urandom_range(0, 9) != 0);
    in.pc    = $urandom & 32'hFFFF_FFFC;
    i12      = 12'($urandom);
    in.imm   = {{20{i12[11]}}, i12};
    if (in.kind == K_SLLI || in.kind == K_SRLI) in.imm = {27'd0, 5'($urandom)};
    if (in.kind == K_SRAI) in.imm = {20'd0, 7'h20, 5'($urandom)};
    in.rs1 = 5'($urandom_range(0, 7)); in.rs2 = 5'($urandom_range(0, 7)); in.rd = 5'($urandom_range(0, 7));
    in.rs1_data = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
    in.rs2_data = ($urandom_range(0, 2) == 0) ? in.rs1_data : $urandom;
    in.pred  = (is_br(in.kind) || in.kind == K_JAL || in.kind == K_JALR) ? 1'($urandom) : 1'b0;
    in.wb_we = 1'($urandom); in.wb_rd = 5'($urandom_range(0, 7)); in.wb_data = $urandom;
    in.f3    = 3'($urandom);
    return in;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_exp(input string tag, input exp_t e);
    cmp({tag, ".valid"}, 32'(EX_MEM_enable_out), 32'(e.valid));
    cmp({tag, ".memread"}, 32'(EX_MEM_MemRead), 32'(e.mr));
    cmp({tag, ".memwrite"}, 32'(EX_MEM_MemWrite), 32'(e.mw));
    cmp({tag, ".memtoreg"}, 32'(EX_MEM_MemToReg), 32'(e.m2r));
    cmp({tag, ".regwrite"}, 32'(EX_MEM_RegWrite), 32'(e.rw));
    cmp({tag, ".redirect"}, 32'(EX_MEM_redirect), 32'(e.redir));
    if (e.valid) begin
      cmp({tag, ".rd"}, 32'(EX_MEM_Rd), 32'(e.rd));
      cmp({tag, ".funct3"}, 32'(EX_MEM_Funct3), 32'(e.f3));
      cmp({tag, ".storedata"}, EX_MEM_StoreData, e.sdata);
      if (e.chk_res) cmp({tag, ".aluresult"}, EX_MEM_ALUResult, e.res);
    end
    if (e.redir) cmp({tag, ".redirect_pc"}, EX_MEM_redirect_pc, e.rpc);
  endtask

  task automatic check_reset();
    cmp("rst.valid", 32'(EX_MEM_enable_out), 32'd0);
    cmp("rst.ctl", 32'({EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_MemToReg, EX_MEM_RegWrite}), 32'd0);
    cmp("rst.redirect", 32'(EX_MEM_redirect), 32'd0);
    cmp("rst.aluresult", EX_MEM_ALUResult, 32'd0);
    cmp("rst.storedata", EX_MEM_StoreData, 32'd0);
    cmp("rst.rd_f3", 32'({EX_MEM_Rd, EX_MEM_Funct3}), 32'd0);
    cmp("rst.redirect_pc", EX_MEM_redirect_pc, RST_PC);
  endtask

  // Monitor: every edge either resets, holds (stall) or retires one expectation.
  always @(posedge clk) begin : mon
    bit was_rst, was_stall;
    was_rst = reset; was_stall = mem_stall;
    #1;
    if (was_rst) begin
      check_reset();
      m_last = '{default: 0};
    end else if (was_stall) begin
      check_exp("hold", m_last);
    end else if (exp_q.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL underflow: output edge with empty queue at %0t", $time);
    end else begin
      m_last = exp_q.pop_front();
      check_exp("xfer", m_last);
    end
  end

  task automatic issue(input instr_t in);
    exp_t e;
    @(negedge clk);
    reset = 1'b0; mem_stall = 1'b0;
    drive(in);
    e = model(in);
    m_squash = m_squash ? 1'b0 : e.redir;
    m_prev = e;
    exp_q.push_back(e);
  endtask

  task automatic stall_cycle(input instr_t junk);
    @(negedge clk);
    reset = 1'b0; mem_stall = 1'b1;
    drive(junk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; mem_stall = 1'b1;
    drive(rand_instr());
    m_squash = 0;
    m_prev = '{default: 0};
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    instr_t i;
    m_squash = 0;
    m_prev = '{default: 0};
    m_last = '{default: 0};
    repeat (2) @(posedge clk);

    issue(mk(K_ADDI, 1, 0, 0, 0, 0, 5));
    issue(mk(K_ADD, 3, 1, 2, 32'd99, 32'd7, 0)); settle();
    cmp("fwd_add", EX_MEM_ALUResult, 32'd12);
    cmp("fwd_add_rw", 32'(EX_MEM_RegWrite), 32'd1);
    issue(mk(K_SRA, 10, 6, 7, 32'h8000_0000, 32'd4, 0)); settle();
    cmp("sra", EX_MEM_ALUResult, 32'hF800_0000);
    issue(mk(K_SLTU, 11, 6, 7, 32'hFFFF_FFFF, 32'd1, 0)); settle();
    cmp("sltu", EX_MEM_ALUResult, 32'd0);
    issue(mk(K_SLT, 11, 6, 7, 32'hFFFF_FFFF, 32'd1, 0)); settle();
    cmp("slt", EX_MEM_ALUResult, 32'd1);
    issue(mk(K_SUB, 11, 6, 7, 32'd3, 32'd5, 0)); settle();
    cmp("sub", EX_MEM_ALUResult, 32'hFFFF_FFFE);

    i = mk(K_BEQ, 0, 6, 7, 32'h42, 32'h42, 32'h20); i.pc = 32'h100;
    issue(i); settle();
    cmp("beq_redirect", 32'(EX_MEM_redirect), 32'd1);
    cmp("beq_target", EX_MEM_redirect_pc, 32'h120);
    issue(mk(K_ADD, 12, 6, 7, 1, 2, 0)); settle();
    cmp("beq_squash", 32'(EX_MEM_enable_out), 32'd0);
    issue(mk(K_ADD, 13, 6, 7, 1, 2, 0)); settle();
    cmp("after_squash_valid", 32'(EX_MEM_enable_out), 32'd1);
    cmp("after_squash_res", EX_MEM_ALUResult, 32'd3);

    i = mk(K_JALR, 1, 6, 0, 32'h203, 0, 32'd4); i.pc = 32'h200;
    issue(i); settle();
    cmp("jalr_redirect", 32'(EX_MEM_redirect), 32'd1);
    cmp("jalr_target", EX_MEM_redirect_pc, 32'h206);
    cmp("jalr_link", EX_MEM_ALUResult, 32'h204);
    issue(mk(K_ADD, 2, 6, 7, 1, 2, 0));

    issue(mk(K_ADDI, 0, 6, 0, 32'h5, 0, 32'h7));
    i = mk(K_ADD, 8, 0, 0, 32'h11, 32'h22, 0);
    i.wb_we = 1; i.wb_rd = 0; i.wb_data = 32'hDEAD;
    issue(i); settle();
    cmp("x0_no_fwd", EX_MEM_ALUResult, 32'h33);

    issue(mk(K_ADDI, 5, 0, 0, 0, 0, 32'h55));
    i = mk(K_ADD, 9, 5, 0, 32'h99, 0, 0);
    i.wb_we = 1; i.wb_rd = 5; i.wb_data = 32'h77;
    issue(i); settle();
    cmp("fwd_priority", EX_MEM_ALUResult, 32'h55);

    i = mk(K_BNE, 0, 6, 7, 1, 2, 32'h40); i.pc = 32'h300;
    issue(i); settle();
    cmp("bne_redirect", 32'(EX_MEM_redirect), 32'd1);
    for (int s = 0; s < 3; s++) begin
      i = rand_instr(); i.valid = 1;
      stall_cycle(i); settle();
      cmp("stall_redirect", 32'(EX_MEM_redirect), 32'd1);
      cmp("stall_target", EX_MEM_redirect_pc, 32'h340);
    end
    issue(mk(K_ADD, 4, 6, 7, 1, 2, 0)); settle();
    cmp("stall_pulse_once", 32'(EX_MEM_redirect), 32'd0);
    cmp("stall_squash", 32'(EX_MEM_enable_out), 32'd0);

    i = mk(K_BEQ, 0, 6, 7, 32'h9, 32'h9, 32'h8); i.pc = 32'h400;
    issue(i); settle();
    cmp("pre_reset_redirect", 32'(EX_MEM_redirect), 32'd1);
    do_reset(); settle();
    cmp("reset_redirect_pc", EX_MEM_redirect_pc, RST_PC);
    issue(mk(K_ADD, 14, 6, 7, 32'd4, 32'd5, 0)); settle();
    cmp("reset_clears_squash", 32'(EX_MEM_enable_out), 32'd1);
    cmp("reset_next_res", EX_MEM_ALUResult, 32'd9);

    for (int n = 0; n < 600; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 15)      stall_cycle(rand_instr());
      else if (r < 17) do_reset();
      else             issue(rand_instr());
    end

    stall_cycle(rand_instr());
    stall_cycle(rand_instr());
    settle();
    cmp("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
